// File: rtl/odd_issue_scoreboard.sv
// Odd-pipe issue stage: RAW hazard scoreboard over in-flight destinations plus issue register.
// Build option ODD_ISSUE_FWD_EN: counters load in_latency-1 (forwarding) instead of WB_DEPTH.
module odd_issue_scoreboard #(
  parameter int unsigned NREG     = 128,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned WB_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [6:0]              in_instr_id,
  input  logic [2:0]              in_unit_id,
  input  logic [3:0]              in_latency,
  input  logic                    in_reg_wr,
  input  logic [$clog2(NREG)-1:0] in_reg_dst,
  input  logic [$clog2(NREG)-1:0] in_ra,
  input  logic [$clog2(NREG)-1:0] in_rb,
  input  logic [$clog2(NREG)-1:0] in_rc,
  input  logic                    in_use_ra,
  input  logic                    in_use_rb,
  input  logic                    in_use_rc,
  input  logic [9:0]              in_pc,
  output logic                    iss_valid,
  output logic [6:0]              iss_instr_id,
  output logic [2:0]              iss_unit_id,
  output logic [3:0]              iss_latency,
  output logic                    iss_reg_wr,
  output logic [$clog2(NREG)-1:0] iss_reg_dst,
  output logic [$clog2(NREG)-1:0] iss_ra,
  output logic [$clog2(NREG)-1:0] iss_rb,
  output logic [$clog2(NREG)-1:0] iss_rc,
  output logic [9:0]              iss_pc,
  output logic [15:0]             stall_cycles
);

  localparam int unsigned RW = $clog2(NREG);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RW-1:0]    reg_t;

  function automatic cnt_t dec_sat(input cnt_t v);
    return (v == '0) ? '0 : v - cnt_t'(1);
  endfunction

  cnt_t        cnt_q [NREG];
  cnt_t        cnt_d [NREG];
  cnt_t        prev_cnt_q, prev_cnt_d;
  reg_t        prev_dst_q, prev_dst_d;

  logic        iss_valid_q, iss_valid_d;
  logic [6:0]  iss_instr_id_q, iss_instr_id_d;
  logic [2:0]  iss_unit_id_q, iss_unit_id_d;
  logic [3:0]  iss_latency_q, iss_latency_d;
  logic        iss_reg_wr_q, iss_reg_wr_d;
  reg_t        iss_reg_dst_q, iss_reg_dst_d;
  reg_t        iss_ra_q, iss_ra_d;
  reg_t        iss_rb_q, iss_rb_d;
  reg_t        iss_rc_q, iss_rc_d;
  logic [9:0]  iss_pc_q, iss_pc_d;
  logic [15:0] stall_q, stall_d;

  logic        hazard;
  logic        accept;
  cnt_t        load_val;

`ifdef ODD_ISSUE_FWD_EN
  assign load_val = (in_latency == '0) ? '0 : cnt_t'(in_latency - 4'd1);
`else
  assign load_val = cnt_t'(WB_DEPTH);
`endif

  assign hazard   = (in_use_ra && (cnt_q[in_ra] != '0)) ||
                    (in_use_rb && (cnt_q[in_rb] != '0)) ||
                    (in_use_rc && (cnt_q[in_rc] != '0));
  assign in_ready = !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      cnt_d[i] = dec_sat(cnt_q[i]);
    end
    prev_cnt_d = prev_cnt_q;
    prev_dst_d = prev_dst_q;
    // The saved count is already aged by this cycle's decrement, so a restore one
    // cycle later lands on the value the overwritten write would have reached.
    if (flush && iss_valid_q && iss_reg_wr_q) begin
      cnt_d[prev_dst_q] = dec_sat(prev_cnt_q);
    end
    if (accept && in_reg_wr) begin
      cnt_d[in_reg_dst] = load_val;
      prev_cnt_d        = dec_sat(cnt_q[in_reg_dst]);
      prev_dst_d        = in_reg_dst;
    end
  end

  always_comb begin
    iss_valid_d    = accept;
    iss_instr_id_d = iss_instr_id_q;
    iss_unit_id_d  = iss_unit_id_q;
    iss_latency_d  = iss_latency_q;
    iss_reg_wr_d   = iss_reg_wr_q;
    iss_reg_dst_d  = iss_reg_dst_q;
    iss_ra_d       = iss_ra_q;
    iss_rb_d       = iss_rb_q;
    iss_rc_d       = iss_rc_q;
    iss_pc_d       = iss_pc_q;
    if (accept) begin
      iss_instr_id_d = in_instr_id;
      iss_unit_id_d  = in_unit_id;
      iss_latency_d  = in_latency;
      iss_reg_wr_d   = in_reg_wr;
      iss_reg_dst_d  = in_reg_dst;
      iss_ra_d       = in_ra;
      iss_rb_d       = in_rb;
      iss_rc_d       = in_rc;
      iss_pc_d       = in_pc;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != '1)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= '0;
      end
      prev_cnt_q     <= '0;
      prev_dst_q     <= '0;
      iss_valid_q    <= 1'b0;
      iss_instr_id_q <= '0;
      iss_unit_id_q  <= '0;
      iss_latency_q  <= '0;
      iss_reg_wr_q   <= 1'b0;
      iss_reg_dst_q  <= '0;
      iss_ra_q       <= '0;
      iss_rb_q       <= '0;
      iss_rc_q       <= '0;
      iss_pc_q       <= '0;
      stall_q        <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      prev_cnt_q     <= prev_cnt_d;
      prev_dst_q     <= prev_dst_d;
      iss_valid_q    <= iss_valid_d;
      iss_instr_id_q <= iss_instr_id_d;
      iss_unit_id_q  <= iss_unit_id_d;
      iss_latency_q  <= iss_latency_d;
      iss_reg_wr_q   <= iss_reg_wr_d;
      iss_reg_dst_q  <= iss_reg_dst_d;
      iss_ra_q       <= iss_ra_d;
      iss_rb_q       <= iss_rb_d;
      iss_rc_q       <= iss_rc_d;
      iss_pc_q       <= iss_pc_d;
      stall_q        <= stall_d;
    end
  end

  assign iss_valid    = iss_valid_q;
  assign iss_instr_id = iss_instr_id_q;
  assign iss_unit_id  = iss_unit_id_q;
  assign iss_latency  = iss_latency_q;
  assign iss_reg_wr   = iss_reg_wr_q;
  assign iss_reg_dst  = iss_reg_dst_q;
  assign iss_ra       = iss_ra_q;
  assign iss_rb       = iss_rb_q;
  assign iss_rc       = iss_rc_q;
  assign iss_pc       = iss_pc_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_odd_issue_scoreboard.sv
// Directed bench for odd_issue_scoreboard: expected issues queued at drive time, checked on issue.
module tb_odd_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [6:0]  in_instr_id;
  logic [2:0]  in_unit_id;
  logic [3:0]  in_latency;
  logic        in_reg_wr;
  logic [6:0]  in_reg_dst, in_ra, in_rb, in_rc;
  logic        in_use_ra, in_use_rb, in_use_rc;
  logic [9:0]  in_pc;
  logic        iss_valid;
  logic [6:0]  iss_instr_id;
  logic [2:0]  iss_unit_id;
  logic [3:0]  iss_latency;
  logic        iss_reg_wr;
  logic [6:0]  iss_reg_dst, iss_ra, iss_rb, iss_rc;
  logic [9:0]  iss_pc;
  logic [15:0] stall_cycles;

  odd_issue_scoreboard #(.NREG(128), .CNT_W(4), .WB_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr_id(in_instr_id), .in_unit_id(in_unit_id), .in_latency(in_latency),
    .in_reg_wr(in_reg_wr), .in_reg_dst(in_reg_dst), .in_ra(in_ra), .in_rb(in_rb),
    .in_rc(in_rc), .in_use_ra(in_use_ra), .in_use_rb(in_use_rb), .in_use_rc(in_use_rc),
    .in_pc(in_pc), .iss_valid(iss_valid), .iss_instr_id(iss_instr_id),
    .iss_unit_id(iss_unit_id), .iss_latency(iss_latency), .iss_reg_wr(iss_reg_wr),
    .iss_reg_dst(iss_reg_dst), .iss_ra(iss_ra), .iss_rb(iss_rb), .iss_rc(iss_rc),
    .iss_pc(iss_pc), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int exp_stall = 0;

  typedef struct {
    logic [52:0] f;
    int unsigned c;
  } exp_t;
  exp_t q[$];

  // Counter value loaded for a writer of the given latency.
  function automatic int ld(input logic [3:0] lat);
`ifdef ODD_ISSUE_FWD_EN
    return (lat == 4'd0) ? 0 : int'(lat) - 1;
`else
    return 8;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] id, input logic [3:0] lat, input logic wr,
                       input logic [6:0] dst, input logic [6:0] ra, input logic [6:0] rb,
                       input logic [6:0] rc, input logic [2:0] use_v, input logic [9:0] pc);
    in_valid    = 1'b1;
    in_instr_id = id;
    in_unit_id  = 3'(3'd5 + 3'(id % 3));
    in_latency  = lat;
    in_reg_wr   = wr;
    in_reg_dst  = dst;
    in_ra       = ra;
    in_rb       = rb;
    in_rc       = rc;
    {in_use_ra, in_use_rb, in_use_rc} = use_v;
    in_pc       = pc;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic [6:0] id, input logic [3:0] lat, input logic wr,
                       input logic [6:0] dst, input logic [6:0] ra, input logic [6:0] rb,
                       input logic [6:0] rc, input logic [2:0] use_v, input logic [9:0] pc,
                       input int exp_wait, output int unsigned acc_cyc);
    int n = 0;
    bit done = 1'b0;
    exp_t e;
    drive(id, lat, wr, dst, ra, rb, rc, use_v, pc);
    #1;
    for (int k = 0; k < 40 && !done; k++) begin
      if (in_ready) done = 1'b1;
      else begin
        n++;
        exp_stall++;
        @(posedge clk); #2;
      end
    end
    chk("stall_wait", 64'(n), 64'(exp_wait));
    acc_cyc = cyc + 1;
    if (done) begin
      e.f = {in_instr_id, in_unit_id, in_latency, in_reg_wr, in_reg_dst, in_ra, in_rb, in_rc, in_pc};
      e.c = cyc + 1;
      q.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && iss_valid) begin
      if (q.size() == 0) chk("spurious_issue", 64'(iss_valid), 64'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("iss_fields", 64'({iss_instr_id, iss_unit_id, iss_latency, iss_reg_wr,
                               iss_reg_dst, iss_ra, iss_rb, iss_rc, iss_pc}), 64'(e.f));
        chk("iss_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  initial begin
    int unsigned a, b;
    rst = 1'b1; flush = 1'b0;
    drive(7'd0, 4'd0, 1'b0, 7'd0, 7'd0, 7'd0, 7'd0, 3'b000, 10'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("rst_iss_fields", 64'({iss_instr_id, iss_unit_id, iss_latency, iss_reg_wr,
                               iss_reg_dst, iss_ra, iss_rb, iss_rc, iss_pc}), 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Independent back-to-back stream
    for (int i = 0; i < 6; i++) begin
      issue(7'(i + 1), 4'd3, 1'b1, 7'(60 + i), 7'(100 + i), 7'(110 + i), 7'(120 + i),
            3'b111, 10'(10'h100 + i * 4), 0, a);
    end
    chk("indep_stall", 64'(stall_cycles), 64'(exp_stall));

    // RAW dependency, latency 4
    issue(7'd10, 4'd4, 1'b1, 7'd5, 7'd0, 7'd0, 7'd0, 3'b000, 10'h200, 0, a);
    issue(7'd11, 4'd1, 1'b1, 7'd6, 7'd5, 7'd0, 7'd0, 3'b100, 10'h204, ld(4'd4), b);
    chk("dep_gap", 64'(b - a), 64'(ld(4'd4) + 1));
    chk("dep_stall", 64'(stall_cycles), 64'(exp_stall));

    // latency 0 treated as 1
    issue(7'd12, 4'd0, 1'b1, 7'd20, 7'd0, 7'd0, 7'd0, 3'b000, 10'h210, 0, a);
    issue(7'd13, 4'd2, 1'b0, 7'd21, 7'd0, 7'd20, 7'd0, 3'b010, 10'h214, ld(4'd0), b);

    // source == destination checks only the old count
    issue(7'd14, 4'd5, 1'b1, 7'd30, 7'd30, 7'd0, 7'd0, 3'b100, 10'h220, 0, a);
    issue(7'd15, 4'd1, 1'b0, 7'd31, 7'd0, 7'd0, 7'd30, 3'b001, 10'h224, ld(4'd5), b);

    // non-writer leaves scoreboard alone
    issue(7'd16, 4'd3, 1'b0, 7'd40, 7'd0, 7'd0, 7'd0, 3'b000, 10'h230, 0, a);
    issue(7'd17, 4'd1, 1'b0, 7'd41, 7'd40, 7'd0, 7'd0, 3'b100, 10'h234, 0, b);

    // unused source ignored, used one stalls
    issue(7'd18, 4'd7, 1'b1, 7'd50, 7'd0, 7'd0, 7'd0, 3'b000, 10'h240, 0, a);
    issue(7'd19, 4'd1, 1'b0, 7'd51, 7'd50, 7'd0, 7'd0, 3'b000, 10'h244, 0, a);
    issue(7'd20, 4'd1, 1'b0, 7'd52, 7'd0, 7'd50, 7'd0, 3'b010, 10'h248, ld(4'd7) - 1, b);
    chk("misc_stall", 64'(stall_cycles), 64'(exp_stall));

    // flush of a WAW write restores its predecessor's count
    issue(7'd21, 4'd6, 1'b1, 7'd9, 7'd0, 7'd0, 7'd0, 3'b000, 10'h250, 0, a);
    issue(7'd22, 4'd2, 1'b1, 7'd9, 7'd0, 7'd0, 7'd0, 3'b000, 10'h254, 0, a);
    flush = 1'b1;
    #1;
    chk("flush_ready_idle", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_kill", 64'(iss_valid), 64'd0);
    issue(7'd23, 4'd1, 1'b0, 7'd10, 7'd9, 7'd0, 7'd0, 3'b100, 10'h258, ld(4'd6) - 2, b);
    chk("flush_stall", 64'(stall_cycles), 64'(exp_stall));

    // flush with a ready instruction: held and accepted next cycle
    drive(7'd24, 4'd2, 1'b1, 7'd70, 7'd0, 7'd0, 7'd0, 3'b000, 10'h3AA);
    flush = 1'b1;
    #1;
    chk("flush_ready_busy", 64'(in_ready), 64'd0);
    exp_stall++;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_no_accept", 64'(iss_valid), 64'd0);
    issue(7'd24, 4'd2, 1'b1, 7'd70, 7'd0, 7'd0, 7'd0, 3'b000, 10'h3AA, 0, a);
    chk("flush_valid_stall", 64'(stall_cycles), 64'(exp_stall));

    // async reset mid-stream
    issue(7'd25, 4'd7, 1'b1, 7'd80, 7'd0, 7'd0, 7'd0, 3'b000, 10'h300, 0, a);
    drive(7'd26, 4'd1, 1'b0, 7'd81, 7'd80, 7'd0, 7'd0, 3'b100, 10'h304);
    #1;
    chk("pre_rst_hazard", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_iss_valid", 64'(iss_valid), 64'd0);
    chk("mid_rst_iss_fields", 64'({iss_instr_id, iss_unit_id, iss_latency, iss_reg_wr,
                                   iss_reg_dst, iss_ra, iss_rb, iss_rc, iss_pc}), 64'd0);
    chk("mid_rst_stall", 64'(stall_cycles), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    q.delete();
    exp_stall = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    issue(7'd26, 4'd1, 1'b0, 7'd81, 7'd80, 7'd0, 7'd0, 3'b100, 10'h304, 0, a);
    chk("post_rst_stall", 64'(stall_cycles), 64'(exp_stall));

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
